// File: rtl/logical_unit_pipe_pkg.sv
// Shared types for the pipelined logical / bit-manipulation unit.
// Op codes 000-010 keep the legacy 2-bit select meaning.
package logical_unit_pipe_pkg;

    localparam int unsigned BITS  = 32;
    localparam int unsigned LOP_W = 3;

    typedef enum logic [LOP_W-1:0] {
        LOP_XOR  = 3'b000,
        LOP_OR   = 3'b001,
        LOP_AND  = 3'b010,
        LOP_ANDN = 3'b011,
        LOP_ORN  = 3'b100,
        LOP_XNOR = 3'b101,
        LOP_CPOP = 3'b110,
        LOP_CLZ  = 3'b111
    } logic_op_t;

endpackage

// File: rtl/logical_unit_pipe_bit_chunk_count.sv
// Per-chunk popcount, leading-zero count (from the chunk MSB) and all-zero flag.
module logical_unit_pipe_bit_chunk_count #(
    parameter int unsigned CHUNK = 8,
    parameter int unsigned CNT_W = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] data,
    output logic [CNT_W-1:0] pop,
    output logic [CNT_W-1:0] lz,
    output logic             all_zero
);

    logic seen_one;

    always_comb begin
        pop      = '0;
        lz       = '0;
        seen_one = 1'b0;
        for (int i = int'(CHUNK) - 1; i >= 0; i--) begin
            pop = pop + CNT_W'(data[i]);
            if (data[i]) begin
                seen_one = 1'b1;
            end else if (!seen_one) begin
                lz = lz + CNT_W'(1);
            end
        end
    end

    assign all_zero = ~|data;

endmodule

// File: rtl/logical_unit_pipe.sv
// Two-stage pipelined logical unit: bitwise ops, CPOP and CLZ with valid/ready on both sides.
// Stage 1 registers bitwise results and per-chunk counts; stage 2 reduces the chunk counts.
module logical_unit_pipe
    import logical_unit_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = BITS,
    parameter int unsigned CHUNK = 8,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [LOP_W-1:0] in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned CW  = $clog2(CHUNK + 1);
    localparam int unsigned RW  = $clog2(WIDTH + 1);

    logic_op_t op_in;
    assign op_in = logic_op_t'(in_op);

    logic [NCH-1:0][CW-1:0] chunk_pop;
    logic [NCH-1:0][CW-1:0] chunk_lz;
    logic [NCH-1:0]         chunk_az;

    // Chunk NCH-1 holds the operand MSBs.
    for (genvar c = 0; c < NCH; c++) begin : gen_chunk
        logical_unit_pipe_bit_chunk_count #(
            .CHUNK (CHUNK),
            .CNT_W (CW)
        ) u_count (
            .data     (in_a[c*CHUNK +: CHUNK]),
            .pop      (chunk_pop[c]),
            .lz       (chunk_lz[c]),
            .all_zero (chunk_az[c])
        );
    end

    logic [WIDTH-1:0] bit_res;

    always_comb begin
        bit_res = '0;
        unique case (op_in)
            LOP_XOR:  bit_res = in_a ^ in_b;
            LOP_OR:   bit_res = in_a | in_b;
            LOP_AND:  bit_res = in_a & in_b;
            LOP_ANDN: bit_res = in_a & ~in_b;
            LOP_ORN:  bit_res = in_a | ~in_b;
            LOP_XNOR: bit_res = ~(in_a ^ in_b);
            default:  bit_res = '0;
        endcase
    end

    logic                   v1_q;
    logic [WIDTH-1:0]       res1_q;
    logic [NCH-1:0][CW-1:0] pop1_q;
    logic [NCH-1:0][CW-1:0] lz1_q;
    logic [NCH-1:0]         az1_q;
    logic_op_t              op1_q;
    logic [TAG_W-1:0]       tag1_q;

    logic                   v2_q;
    logic [WIDTH-1:0]       data2_q;
    logic                   zero2_q;
    logic [TAG_W-1:0]       tag2_q;

    logic ready1;
    logic ready2;

    assign ready2   = !v2_q || out_ready;
    assign ready1   = !v1_q || ready2;
    assign in_ready = ready1;

    logic [RW-1:0]    cpop_sum;
    logic [RW-1:0]    clz_sum;
    logic             clz_done;
    logic [WIDTH-1:0] res2_d;

    always_comb begin
        cpop_sum = '0;
        clz_sum  = '0;
        clz_done = 1'b0;
        for (int c = 0; c < int'(NCH); c++) begin
            cpop_sum = cpop_sum + RW'(pop1_q[c]);
        end
        // Whole zero chunks count CHUNK each until the first chunk holding a one.
        for (int c = int'(NCH) - 1; c >= 0; c--) begin
            if (!clz_done) begin
                if (az1_q[c]) begin
                    clz_sum = clz_sum + RW'(CHUNK);
                end else begin
                    clz_sum  = clz_sum + RW'(lz1_q[c]);
                    clz_done = 1'b1;
                end
            end
        end
        case (op1_q)
            LOP_CPOP: res2_d = WIDTH'(cpop_sum);
            LOP_CLZ:  res2_d = WIDTH'(clz_sum);
            default:  res2_d = res1_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            res1_q  <= '0;
            pop1_q  <= '0;
            lz1_q   <= '0;
            az1_q   <= '0;
            op1_q   <= LOP_XOR;
            tag1_q  <= '0;
            v2_q    <= 1'b0;
            data2_q <= '0;
            zero2_q <= 1'b0;
            tag2_q  <= '0;
        end else begin
            if (ready1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    res1_q <= bit_res;
                    pop1_q <= chunk_pop;
                    lz1_q  <= chunk_lz;
                    az1_q  <= chunk_az;
                    op1_q  <= op_in;
                    tag1_q <= in_tag;
                end
            end
            if (ready2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    data2_q <= res2_d;
                    zero2_q <= (res2_d == '0);
                    tag2_q  <= tag1_q;
                end
            end
        end
    end

    assign out_valid = v2_q;
    assign out_data  = data2_q;
    assign out_zero  = zero2_q;
    assign out_tag   = tag2_q;

endmodule

// File: tb/tb_logical_unit_pipe.sv
// Scoreboard bench for logical_unit_pipe: directed ops, backpressure, random traffic, reset flush.
module tb_logical_unit_pipe;
    import logical_unit_pipe_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned TW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [2:0]    in_op = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_zero;
    logic [TW-1:0] out_tag;

    always #5 clk = ~clk;

    logical_unit_pipe #(
        .WIDTH (W),
        .CHUNK (8),
        .TAG_W (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    typedef struct {
        logic [W-1:0]  data;
        logic          zero;
        logic [TW-1:0] tag;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    logic          lat_check = 1'b0;
    logic          accepted = 1'b0;
    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_data = '0;
    logic          prev_zero = 1'b0;
    logic [TW-1:0] prev_tag = '0;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        int           n;
        n = 0;
        case (op)
            3'd0: r = a ^ b;
            3'd1: r = a | b;
            3'd2: r = a & b;
            3'd3: r = a & ~b;
            3'd4: r = a | ~b;
            3'd5: r = ~(a ^ b);
            3'd6: r = W'($countones(a));
            default: begin
                for (int i = int'(W) - 1; i >= 0 && !a[i]; i--) n++;
                r = W'(n);
            end
        endcase
        return r;
    endfunction

    // One clock: drive at negedge, evaluate both handshakes 1 ns later.
    task automatic step(input logic r, input logic v, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] t, input logic ordy,
                        input logic has_exp, input logic [W-1:0] exp_data);
        exp_t e;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = t;
        out_ready = ordy;
        #1;
        accepted = 1'b0;
        if (r) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_data", out_data, prev_data);
                check_eq("hold_zero", out_zero, prev_zero);
                check_eq("hold_tag", out_tag, prev_tag);
            end
            check_eq("in_ready", in_ready, (sb.size() < 2) || ordy);
            if (out_valid && ordy) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_out", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("out_data", out_data, e.data);
                    check_eq("out_zero", out_zero, e.zero);
                    check_eq("out_tag", out_tag, e.tag);
                    if (lat_check) check_eq("latency", cyc - e.cyc, 2);
                end
            end
            if (v && in_ready) begin
                e.data = has_exp ? exp_data : model(op, a, b);
                e.zero = (e.data == '0);
                e.tag  = t;
                e.cyc  = cyc;
                sb.push_back(e);
                accepted = 1'b1;
            end
            prev_stall = out_valid && !ordy;
            prev_data  = out_data;
            prev_zero  = out_zero;
            prev_tag   = out_tag;
        end
        cyc++;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 3'd0, '0, '0, '0, ordy, 1'b0, '0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] t, input logic ordy);
        step(1'b0, 1'b1, op, a, b, t, ordy, 1'b0, '0);
    endtask

    task automatic issue_exp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [TW-1:0] t, input logic [W-1:0] exp_data);
        step(1'b0, 1'b1, op, a, b, t, 1'b1, 1'b1, exp_data);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] bp_a [4];
        int           acc;
        int           sent;
        int           guard;

        step(1'b1, 1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0, '0);
        idle(1'b1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_zero", out_zero, 0);
        check_eq("rst_out_tag", out_tag, 0);
        check_eq("rst_in_ready", in_ready, 1);

        lat_check = 1'b1;
        issue_exp(LOP_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd1, 32'hFF00_EDCB);
        issue_exp(LOP_OR,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd2, 32'hFFF0_FFFF);
        issue_exp(LOP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd3, 32'h00F0_1234);
        issue_exp(LOP_ANDN, 32'hAAAA_AAAA, 32'hFFFF_0000, 5'd4, 32'h0000_AAAA);
        issue_exp(LOP_ORN,  32'hAAAA_AAAA, 32'hFFFF_0000, 5'd5, 32'hAAAA_FFFF);
        issue_exp(LOP_XNOR, 32'hAAAA_AAAA, 32'hFFFF_0000, 5'd6, 32'hAAAA_5555);
        issue_exp(LOP_CPOP, 32'hFFFF_FFFF, 32'h1234_5678, 5'd7, 32'd32);
        issue_exp(LOP_CPOP, 32'h0000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0);
        issue_exp(LOP_CLZ,  32'h0001_0000, 32'h0, 5'd9, 32'd15);
        issue_exp(LOP_CLZ,  32'h0000_0000, 32'h0, 5'd10, 32'd32);
        issue_exp(LOP_CLZ,  32'h8000_0000, 32'h0, 5'd11, 32'd0);
        repeat (3) idle(1'b1);
        check_eq("dir_drained", sb.size(), 0);
        lat_check = 1'b0;

        bp_a[0] = 32'h1111_0000;
        bp_a[1] = 32'h0F00_0F00;
        bp_a[2] = 32'h0000_0001;
        bp_a[3] = 32'hDEAD_BEEF;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            issue(3'(acc % 8), bp_a[acc], 32'h00FF_00FF, 5'(20 + acc), 1'b0);
            if (accepted) acc++;
        end
        check_eq("bp_accepts", acc, 2);
        check_eq("bp_in_ready", in_ready, 0);
        guard = 0;
        while (acc < 4 && guard < 20) begin
            issue(3'(acc % 8), bp_a[acc], 32'h00FF_00FF, 5'(20 + acc), 1'b1);
            if (accepted) acc++;
            guard++;
        end
        check_eq("bp_all_issued", acc, 4);
        repeat (4) idle(1'b1);
        check_eq("bp_drained", sb.size(), 0);

        sent = 0;
        guard = 0;
        while (sent < 10000 && guard < 60000) begin
            logic [W-1:0] ra;
            ra = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) ra = '0;
            step(1'b0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), ra, $urandom,
                 5'($urandom), $urandom_range(0, 3) != 0, 1'b0, '0);
            if (accepted) sent++;
            guard++;
        end
        check_eq("rand_sent", sent, 10000);
        repeat (6) idle(1'b1);
        check_eq("rand_drained", sb.size(), 0);

        issue(LOP_OR, 32'h0000_00F0, 32'h0000_000F, 5'd30, 1'b0);
        issue(LOP_CLZ, 32'h0000_0100, 32'h0, 5'd31, 1'b0);
        step(1'b1, 1'b0, 3'd0, '0, '0, '0, 1'b1, 1'b0, '0);
        idle(1'b1);
        check_eq("flush_out_valid", out_valid, 0);
        check_eq("flush_out_data", out_data, 0);
        check_eq("flush_out_tag", out_tag, 0);
        check_eq("flush_in_ready", in_ready, 1);
        repeat (5) idle(1'b1);
        lat_check = 1'b1;
        issue_exp(LOP_CLZ, 32'h0000_00FF, 32'h0, 5'd17, 32'd24);
        repeat (3) idle(1'b1);
        check_eq("post_flush_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
